aclk_alarm_bank: RTL and testbench

Multi-channel alarm operation unit for the alarm clock, successor to the single-alarm operator. Holds `NUM_AL` independently programmable alarm times, compares them against the running time from the timekeeping counter, and arbitrates a single `Alarm` output. Adds ring timeout and optional snooze. Sits between the time counter and the buzzer driver, on the 10 Hz system clock.

---
 rtl/aclk_pkg.sv | 26 ++
 rtl/aclk_al_channel.sv | 43 ++++
 rtl/aclk_alarm_bank.sv | 156 +++++++++++++++
 tb/tb_aclk_alarm_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared types and limits for the alarm bank.
// State enum, stored-time struct, time-field bounds.
package aclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } aclk_al_state_t;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
  } aclk_time_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  function automatic logic time_ok(
    input aclk_time_t t
  );
    return (t.hour <= MAX_HOUR) &&
           (t.min <= MAX_MIN);
  endfunction

endpackage

// File: rtl/aclk_al_channel.sv
// aclk_al_channel: one alarm slot.
// Stored time, validated load, match and pending flag.
module aclk_al_channel
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  aclk_time_t ld_time,
  input  logic       sec_tick,
  input  aclk_time_t cur_time,
  input  logic [5:0] cur_sec,
  input  logic       en,
  input  logic       clr,
  output logic       pending
);

  aclk_time_t al_time;
  logic       match;

  assign match = sec_tick && en &&
                 (cur_sec == 6'd0) &&
                 (cur_time == al_time);

  // stored time: out-of-range loads are dropped
  always_ff @(posedge clk) begin
    if (reset)
      al_time <= '0;
    else if (ld && time_ok(ld_time))
      al_time <= ld_time;
  end

  // pending: disable or arbiter clear wins over a match
  always_ff @(posedge clk) begin
    if (reset)
      pending <= 1'b0;
    else if (!en || clr)
      pending <= 1'b0;
    else if (match)
      pending <= 1'b1;
  end

endmodule

// File: rtl/aclk_alarm_bank.sv
// aclk_alarm_bank: NUM_AL alarm channels, one buzzer request.
// Optional snooze state built when ACLK_SNOOZE_EN is defined.
module aclk_alarm_bank
  import aclk_pkg::*;
#(
  parameter int NUM_AL         = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int AL_IDX_W       = $clog2(NUM_AL)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [4:0]          cur_hour,
  input  logic [5:0]          cur_min,
  input  logic [5:0]          cur_sec,
  input  logic                LD_alarm,
  input  logic [AL_IDX_W-1:0] al_sel,
  input  logic [4:0]          al_hour,
  input  logic [5:0]          al_min,
  input  logic [NUM_AL-1:0]   AL_ON,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [AL_IDX_W-1:0] alarm_src,
  output logic [NUM_AL-1:0]   al_pending
);

  localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [RING_W-1:0] RING_LAST =
    RING_W'(RING_TIMEOUT_S - 1);

  aclk_al_state_t      state;
  logic [RING_W-1:0]   ring_cnt;
  logic [NUM_AL-1:0]   clr_vec;
  logic [AL_IDX_W-1:0] first_idx;
  logic                stop_req;
  logic                ring_done;
  logic                end_ep;
  aclk_time_t          ld_time;
  aclk_time_t          cur_time;

  assign ld_time  = '{hour: al_hour, min: al_min};
  assign cur_time = '{hour: cur_hour, min: cur_min};

`ifdef ACLK_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam logic [SNZ_W-1:0] SNZ_LAST =
    SNZ_W'(SNZ_TICKS - 1);

  logic [SNZ_W-1:0] snz_cnt;
  logic             snz_done;

  assign snz_done = sec_tick && (snz_cnt == SNZ_LAST);
`else
  logic unused_snooze;

  assign unused_snooze = SNOOZE;
`endif

  assign stop_req  = STOP_al || !AL_ON[alarm_src];
  assign ring_done = sec_tick && (ring_cnt == RING_LAST);

  // lowest-index pending channel wins the next episode
  always_comb begin
    first_idx = '0;
    for (int i = NUM_AL - 1; i >= 0; i--)
      if (al_pending[i])
        first_idx = AL_IDX_W'(i);
  end

  // clear the serving channel when its episode ends
  always_comb begin
    end_ep = ((state == ST_RING) &&
              (stop_req || ring_done)) ||
             ((state == ST_SNOOZE) && stop_req);
    clr_vec = '0;
    for (int i = 0; i < NUM_AL; i++)
      clr_vec[i] = end_ep &&
                   (alarm_src == AL_IDX_W'(i));
  end

  for (genvar g = 0; g < NUM_AL; g++) begin : g_ch
    aclk_al_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .ld       (LD_alarm &&
                 (al_sel == AL_IDX_W'(g))),
      .ld_time  (ld_time),
      .sec_tick (sec_tick),
      .cur_time (cur_time),
      .cur_sec  (cur_sec),
      .en       (AL_ON[g]),
      .clr      (clr_vec[g]),
      .pending  (al_pending[g])
    );
  end

  // arbiter FSM with registered buzzer and source outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      Alarm     <= 1'b0;
      alarm_src <= '0;
      ring_cnt  <= '0;
`ifdef ACLK_SNOOZE_EN
      snz_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|al_pending) begin
            state     <= ST_RING;
            alarm_src <= first_idx;
            ring_cnt  <= '0;
            Alarm     <= 1'b1;
          end
        end
        ST_RING: begin
          if (stop_req || ring_done) begin
            state <= ST_IDLE;
            Alarm <= 1'b0;
          end
`ifdef ACLK_SNOOZE_EN
          else if (SNOOZE) begin
            state   <= ST_SNOOZE;
            snz_cnt <= '0;
            Alarm   <= 1'b0;
          end
`endif
          else if (sec_tick)
            ring_cnt <= ring_cnt + 1'b1;
        end
`ifdef ACLK_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_req) begin
            state <= ST_IDLE;
            Alarm <= 1'b0;
          end else if (snz_done) begin
            state    <= ST_RING;
            ring_cnt <= '0;
            Alarm    <= 1'b1;
          end else if (sec_tick)
            snz_cnt <= snz_cnt + 1'b1;
        end
`endif
        default: begin
          state <= ST_IDLE;
          Alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_alarm_bank.sv
// tb_aclk_alarm_bank: directed scoreboard bench.
// Expectations follow ACLK_SNOOZE_EN like the design.
`timescale 1ns/1ps
module tb_aclk_alarm_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       LD_alarm;
  logic [1:0] al_sel;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic [3:0] AL_ON;
  logic       STOP_al;
  logic       SNOOZE;
  logic       Alarm;
  logic [1:0] alarm_src;
  logic [3:0] al_pending;

  typedef struct packed {
    logic       alarm;
    logic [1:0] src;
    logic [3:0] pend;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  aclk_alarm_bank dut (
    .clk        (clk),
    .reset      (reset),
    .sec_tick   (sec_tick),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .LD_alarm   (LD_alarm),
    .al_sel     (al_sel),
    .al_hour    (al_hour),
    .al_min     (al_min),
    .AL_ON      (AL_ON),
    .STOP_al    (STOP_al),
    .SNOOZE     (SNOOZE),
    .Alarm      (Alarm),
    .alarm_src  (alarm_src),
    .al_pending (al_pending)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(
    input string      tag,
    input logic       a,
    input logic [1:0] s,
    input logic [3:0] p
  );
    obs_t e;
    e.alarm = a;
    e.src   = s;
    e.pend  = p;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    obs_t  e;
    obs_t  o;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o.alarm = Alarm;
      o.src   = alarm_src;
      o.pend  = al_pending;
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed alarm=%b src=%0d pend=%b, expected alarm=%b src=%0d pend=%b",
               t, o.alarm, o.src, o.pend,
               e.alarm, e.src, e.pend);
      end
    end
  endtask

  task automatic step(
    input string      tag,
    input logic       a,
    input logic [1:0] s,
    input logic [3:0] p
  );
    push_exp(tag, a, s, p);
    cyc();
    pop_check();
  endtask

  task automatic set_time(
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] s
  );
    cur_hour = h;
    cur_min  = m;
    cur_sec  = s;
    sec_tick = 1'b1;
  endtask

  task automatic tick(
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] s
  );
    set_time(h, m, s);
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic load(
    input logic [1:0] sel,
    input logic [4:0] h,
    input logic [5:0] m
  );
    LD_alarm = 1'b1;
    al_sel   = sel;
    al_hour  = h;
    al_min   = m;
    cyc();
    LD_alarm = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    sec_tick = 1'b0;
    cur_hour = '0;
    cur_min  = '0;
    cur_sec  = 6'd1;
    LD_alarm = 1'b0;
    al_sel   = '0;
    al_hour  = '0;
    al_min   = '0;
    AL_ON    = '0;
    STOP_al  = 1'b0;
    SNOOZE   = 1'b0;
    cyc();
    step("reset_state", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;

    // single channel ring and stop
    load(2'd1, 5'd7, 6'd30);
    AL_ON = 4'b0010;
    set_time(5'd7, 6'd30, 6'd0);
    step("a_match", 1'b0, 2'd0, 4'b0010);
    sec_tick = 1'b0;
    step("a_ring", 1'b1, 2'd1, 4'b0010);
    STOP_al = 1'b1;
    step("a_stop", 1'b0, 2'd1, 4'b0000);
    STOP_al = 1'b0;
    step("a_idle", 1'b0, 2'd1, 4'b0000);

    // two channels on the same minute
    load(2'd0, 5'd6, 6'd0);
    load(2'd2, 5'd6, 6'd0);
    AL_ON = 4'b0101;
    set_time(5'd6, 6'd0, 6'd0);
    step("b_match", 1'b0, 2'd1, 4'b0101);
    sec_tick = 1'b0;
    step("b_ring0", 1'b1, 2'd0, 4'b0101);
    STOP_al = 1'b1;
    step("b_gap", 1'b0, 2'd0, 4'b0100);
    STOP_al = 1'b0;
    step("b_ring2", 1'b1, 2'd2, 4'b0100);
    STOP_al = 1'b1;
    step("b_stop2", 1'b0, 2'd2, 4'b0000);
    STOP_al = 1'b0;

    // unattended ring times out
    load(2'd3, 5'd8, 6'd0);
    AL_ON = 4'b1000;
    set_time(5'd8, 6'd0, 6'd0);
    step("c_match", 1'b0, 2'd2, 4'b1000);
    sec_tick = 1'b0;
    step("c_ring", 1'b1, 2'd3, 4'b1000);
    for (int i = 1; i < 59; i++)
      tick(5'd8, 6'd0, 6'(i));
    set_time(5'd8, 6'd0, 6'd59);
    step("c_tick59", 1'b1, 2'd3, 4'b1000);
    set_time(5'd8, 6'd1, 6'd0);
    step("c_timeout", 1'b0, 2'd3, 4'b0000);
    sec_tick = 1'b0;

    // snooze request while ringing
    set_time(5'd8, 6'd0, 6'd0);
    step("d_match", 1'b0, 2'd3, 4'b1000);
    sec_tick = 1'b0;
    step("d_ring", 1'b1, 2'd3, 4'b1000);
    SNOOZE = 1'b1;
`ifdef ACLK_SNOOZE_EN
    step("d_snooze", 1'b0, 2'd3, 4'b1000);
    SNOOZE = 1'b0;
    for (int i = 1; i < 299; i++)
      tick(5'd8, 6'd2, 6'(i % 60));
    set_time(5'd8, 6'd2, 6'd59);
    step("d_snz299", 1'b0, 2'd3, 4'b1000);
    set_time(5'd8, 6'd3, 6'd0);
    step("d_rering", 1'b1, 2'd3, 4'b1000);
    sec_tick = 1'b0;
`else
    step("d_nosnooze", 1'b1, 2'd3, 4'b1000);
    SNOOZE = 1'b0;
    step("d_still", 1'b1, 2'd3, 4'b1000);
`endif
    STOP_al = 1'b1;
    step("d_stop", 1'b0, 2'd3, 4'b0000);
    STOP_al = 1'b0;

    // out-of-range loads, then disable mid-ring
    load(2'd1, 5'd24, 6'd0);
    load(2'd1, 5'd7, 6'd60);
    AL_ON = 4'b0010;
    set_time(5'd7, 6'd30, 6'd0);
    step("e_keep", 1'b0, 2'd3, 4'b0010);
    sec_tick = 1'b0;
    step("e_ring", 1'b1, 2'd1, 4'b0010);
    AL_ON = 4'b0000;
    step("e_disable", 1'b0, 2'd1, 4'b0000);

    // reset in the middle of a ring
    load(2'd0, 5'd7, 6'd30);
    AL_ON = 4'b0011;
    set_time(5'd7, 6'd30, 6'd0);
    step("f_match", 1'b0, 2'd1, 4'b0011);
    sec_tick = 1'b0;
    step("f_ring", 1'b1, 2'd0, 4'b0011);
    reset = 1'b1;
    step("f_reset", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;
    AL_ON = 4'b1111;
    set_time(5'd0, 6'd0, 6'd0);
    step("f_zero_times", 1'b0, 2'd0, 4'b1111);
    sec_tick = 1'b0;
    step("f_ring_low", 1'b1, 2'd0, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
